param_fifo: RTL and testbench

Parametrised synchronous FIFO, the successor to the basic `fifo` in the packet-parser datapath. It adds:
- a selectable read mode: standard registered read, or first-word-fall-through (FWFT);
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- a synchronous flush;
- sticky overflow and underflow error flags.

It sits between the packet parser's input stage and the header/payload consumers, buffering parsed words.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_mem.sv | 29 ++
 rtl/param_fifo.sv | 160 ++++++++++++++++
 tb/tb_param_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised packet-parser FIFO.
package fifo_pkg;

   // Read-side behaviour: registered read or first-word-fall-through.
   typedef enum logic {
      MODE_STD  = 1'b0,
      MODE_FWFT = 1'b1
   } fifo_mode_e;

   // True when v is a non-zero power of two.
   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// No reset; contents are only meaningful between the FIFO pointers.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store one word per accepted write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with STD/FWFT read modes, programmable
// almost-full/almost-empty thresholds, occupancy count, synchronous flush
// and sticky overflow/underflow flags.
module param_fifo
   import fifo_pkg::*;
#(
   parameter int         WIDTH     = 32,
   parameter int         DEPTH     = 16,
   parameter fifo_mode_e MODE      = MODE_STD,
   parameter int         AF_THRESH = DEPTH - 2,
   parameter int         AE_THRESH = 2,
   localparam int        PW        = $clog2(DEPTH),
   localparam int        CW        = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   input  logic             wr_en,
   output logic             full_flag,
   output logic             almost_full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rdata,
   output logic             empty_flag,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   input  logic             err_clr,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   // Elaboration-time parameter sanity checks.
   if (WIDTH < 1) begin : g_bad_width
      $error("param_fifo: WIDTH must be at least 1");
   end
   if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
      $error("param_fifo: DEPTH must be a power of 2 and at least 4");
   end
   if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
      $error("param_fifo: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
   end

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr_nxt;
   logic [PW-1:0]    rd_ptr_nxt;
   logic [CW-1:0]    count_nxt;
   logic             wr_acc;
   logic             rd_acc;
   logic             ovf_set;
   logic             unf_set;
   logic [WIDTH-1:0] mem_rdata;

   // Flush wins over both requests; the flags below come from the registered
   // count, so a read frees a slot for writing only on the following cycle.
   assign wr_acc  = wr_en & ~full_flag  & ~flush;
   assign rd_acc  = rd_en & ~empty_flag & ~flush;
   assign ovf_set = wr_en & full_flag  & ~flush;
   assign unf_set = rd_en & empty_flag & ~flush;

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   // Next pointer and occupancy values.
   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      count_nxt  = count;
      if (flush) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         count_nxt  = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_nxt = wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
         endcase
      end
   end

   // Pointer, count and status-flag registers; flags track the new count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty_flag   <= 1'b1;
         almost_empty <= 1'b1;
         full_flag    <= 1'b0;
         almost_full  <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_nxt;
         rd_ptr       <= rd_ptr_nxt;
         count        <= count_nxt;
         empty_flag   <= (count_nxt == '0);
         almost_empty <= (count_nxt <= AE_C);
         full_flag    <= (count_nxt == DEPTH_C);
         almost_full  <= (count_nxt >= AF_C);
      end
   end

   // Sticky error flags; a new error in the same cycle as err_clr survives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
         if (unf_set) begin
            underflow <= 1'b1;
         end else if (err_clr) begin
            underflow <= 1'b0;
         end
      end
   end

   if (MODE == MODE_STD) begin : g_std
      logic [WIDTH-1:0] rdata_q;

      // Registered read: capture the head word on each accepted read.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            rdata_q <= '0;
         end else if (rd_acc) begin
            rdata_q <= mem_rdata;
         end
      end

      assign rdata = rdata_q;
   end else begin : g_fwft
      // Head word is presented directly; while empty the unreset array would
      // show stale data, so drive zero to keep the output defined.
      assign rdata = empty_flag ? '0 : mem_rdata;
   end

endmodule

// File: tb/tb_param_fifo.sv
// Directed test of param_fifo: one MODE_STD and one MODE_FWFT instance.
module tb_param_fifo;
   import fifo_pkg::*;

   logic        clk;
   logic        rst;

   logic        s_flush, s_wr_en, s_rd_en, s_err_clr;
   logic [31:0] s_wdata, s_rdata;
   logic        s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
   logic [4:0]  s_count;

   logic        f_flush, f_wr_en, f_rd_en, f_err_clr;
   logic [31:0] f_wdata, f_rdata;
   logic        f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
   logic [4:0]  f_count;

   int n_vec;
   int n_err;
   logic [31:0] q[$];
   logic [31:0] exp_d;

   param_fifo #(.WIDTH(32), .DEPTH(16), .MODE(MODE_STD)) u_std (
      .clk(clk), .rst(rst), .flush(s_flush), .wdata(s_wdata), .wr_en(s_wr_en),
      .full_flag(s_full), .almost_full(s_af), .rd_en(s_rd_en), .rdata(s_rdata),
      .empty_flag(s_empty), .almost_empty(s_ae), .count(s_count),
      .err_clr(s_err_clr), .overflow(s_ovf), .underflow(s_unf)
   );

   param_fifo #(.WIDTH(32), .DEPTH(16), .MODE(MODE_FWFT)) u_fwft (
      .clk(clk), .rst(rst), .flush(f_flush), .wdata(f_wdata), .wr_en(f_wr_en),
      .full_flag(f_full), .almost_full(f_af), .rd_en(f_rd_en), .rdata(f_rdata),
      .empty_flag(f_empty), .almost_empty(f_ae), .count(f_count),
      .err_clr(f_err_clr), .overflow(f_ovf), .underflow(f_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic s_push(input logic [31:0] d);
      s_wdata = d;
      s_wr_en = 1'b1;
      tick();
      s_wr_en = 1'b0;
   endtask

   task automatic s_pop;
      s_rd_en = 1'b1;
      tick();
      s_rd_en = 1'b0;
   endtask

   task automatic test_reset;
      n_vec++; if (s_count !== 5'd0)  begin $display("FAIL reset_count got %0d exp 0", s_count); n_err++; end
      n_vec++; if (s_empty !== 1'b1)  begin $display("FAIL reset_empty got %b exp 1", s_empty); n_err++; end
      n_vec++; if (s_ae !== 1'b1)     begin $display("FAIL reset_almost_empty got %b exp 1", s_ae); n_err++; end
      n_vec++; if (s_full !== 1'b0)   begin $display("FAIL reset_full got %b exp 0", s_full); n_err++; end
      n_vec++; if (s_af !== 1'b0)     begin $display("FAIL reset_almost_full got %b exp 0", s_af); n_err++; end
      n_vec++; if (s_rdata !== 32'd0) begin $display("FAIL reset_rdata got %h exp 0", s_rdata); n_err++; end
      n_vec++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin $display("FAIL reset_err got ovf=%b unf=%b exp 0/0", s_ovf, s_unf); n_err++; end
      n_vec++; if (f_empty !== 1'b1 || f_rdata !== 32'd0) begin $display("FAIL reset_fwft got empty=%b rdata=%h exp 1/0", f_empty, f_rdata); n_err++; end
   endtask

   task automatic test_fill_drain;
      for (int k = 0; k < 16; k++) begin
         s_push(32'(k));
         n_vec++; if (s_count !== 5'(k + 1)) begin $display("FAIL fill_count[%0d] got %0d exp %0d", k, s_count, k + 1); n_err++; end
         n_vec++; if (s_full !== (k == 15)) begin $display("FAIL fill_full[%0d] got %b exp %b", k, s_full, (k == 15)); n_err++; end
         n_vec++; if (s_af !== (k + 1 >= 14)) begin $display("FAIL fill_almost_full[%0d] got %b exp %b", k, s_af, (k + 1 >= 14)); n_err++; end
         n_vec++; if (s_ae !== (k + 1 <= 2)) begin $display("FAIL fill_almost_empty[%0d] got %b exp %b", k, s_ae, (k + 1 <= 2)); n_err++; end
         n_vec++; if (s_empty !== 1'b0) begin $display("FAIL fill_empty[%0d] got %b exp 0", k, s_empty); n_err++; end
      end
      for (int k = 0; k < 16; k++) begin
         s_pop();
         n_vec++; if (s_rdata !== 32'(k)) begin $display("FAIL drain_rdata[%0d] got %0d exp %0d", k, s_rdata, k); n_err++; end
         n_vec++; if (s_count !== 5'(15 - k)) begin $display("FAIL drain_count[%0d] got %0d exp %0d", k, s_count, 15 - k); n_err++; end
         n_vec++; if (s_full !== 1'b0) begin $display("FAIL drain_full[%0d] got %b exp 0", k, s_full); n_err++; end
      end
      n_vec++; if (s_empty !== 1'b1) begin $display("FAIL drain_empty got %b exp 1", s_empty); n_err++; end
   endtask

   task automatic test_overflow_underflow;
      for (int k = 0; k < 16; k++) s_push(32'(100 + k));
      s_push(32'd99);
      n_vec++; if (s_count !== 5'd16) begin $display("FAIL ovf_count got %0d exp 16", s_count); n_err++; end
      n_vec++; if (s_ovf !== 1'b1)    begin $display("FAIL ovf_flag got %b exp 1", s_ovf); n_err++; end
      n_vec++; if (s_unf !== 1'b0)    begin $display("FAIL ovf_unf got %b exp 0", s_unf); n_err++; end
      for (int k = 0; k < 16; k++) begin
         s_pop();
         n_vec++; if (s_rdata !== 32'(100 + k)) begin $display("FAIL ovf_drain[%0d] got %0d exp %0d", k, s_rdata, 100 + k); n_err++; end
      end
      n_vec++; if (s_empty !== 1'b1) begin $display("FAIL ovf_drain_empty got %b exp 1", s_empty); n_err++; end
      s_pop();
      n_vec++; if (s_unf !== 1'b1)     begin $display("FAIL unf_flag got %b exp 1", s_unf); n_err++; end
      n_vec++; if (s_rdata !== 32'd115) begin $display("FAIL unf_rdata got %0d exp 115", s_rdata); n_err++; end
      n_vec++; if (s_count !== 5'd0)   begin $display("FAIL unf_count got %0d exp 0", s_count); n_err++; end
      s_err_clr = 1'b1;
      s_rd_en   = 1'b1;
      tick();
      s_rd_en   = 1'b0;
      n_vec++; if (s_unf !== 1'b1) begin $display("FAIL clr_set_wins_unf got %b exp 1", s_unf); n_err++; end
      n_vec++; if (s_ovf !== 1'b0) begin $display("FAIL clr_ovf got %b exp 0", s_ovf); n_err++; end
      tick();
      s_err_clr = 1'b0;
      n_vec++; if (s_unf !== 1'b0) begin $display("FAIL clr_unf got %b exp 0", s_unf); n_err++; end
   endtask

   task automatic test_simultaneous;
      q.delete();
      for (int k = 0; k < 8; k++) begin
         s_push(32'(200 + k));
         q.push_back(32'(200 + k));
      end
      for (int k = 0; k < 20; k++) begin
         s_wdata = 32'(300 + k);
         s_wr_en = 1'b1;
         s_rd_en = 1'b1;
         tick();
         exp_d = q.pop_front();
         q.push_back(32'(300 + k));
         n_vec++; if (s_rdata !== exp_d)  begin $display("FAIL simul_rdata[%0d] got %0d exp %0d", k, s_rdata, exp_d); n_err++; end
         n_vec++; if (s_count !== 5'd8)   begin $display("FAIL simul_count[%0d] got %0d exp 8", k, s_count); n_err++; end
      end
      s_wr_en = 1'b0;
      s_rd_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         s_pop();
         exp_d = q.pop_front();
         n_vec++; if (s_rdata !== exp_d) begin $display("FAIL simul_drain[%0d] got %0d exp %0d", k, s_rdata, exp_d); n_err++; end
      end
      for (int k = 0; k < 16; k++) s_push(32'(400 + k));
      s_wdata = 32'd999;
      s_wr_en = 1'b1;
      s_rd_en = 1'b1;
      tick();
      s_wr_en = 1'b0;
      s_rd_en = 1'b0;
      n_vec++; if (s_count !== 5'd15)   begin $display("FAIL full_rw_count got %0d exp 15", s_count); n_err++; end
      n_vec++; if (s_rdata !== 32'd400) begin $display("FAIL full_rw_rdata got %0d exp 400", s_rdata); n_err++; end
      n_vec++; if (s_full !== 1'b0)     begin $display("FAIL full_rw_full got %b exp 0", s_full); n_err++; end
      n_vec++; if (s_ovf !== 1'b1)      begin $display("FAIL full_rw_ovf got %b exp 1", s_ovf); n_err++; end
      for (int k = 0; k < 15; k++) begin
         s_pop();
         n_vec++; if (s_rdata !== 32'(401 + k)) begin $display("FAIL full_rw_drain[%0d] got %0d exp %0d", k, s_rdata, 401 + k); n_err++; end
      end
      s_wdata = 32'd555;
      s_wr_en = 1'b1;
      s_rd_en = 1'b1;
      tick();
      s_wr_en = 1'b0;
      s_rd_en = 1'b0;
      n_vec++; if (s_count !== 5'd1)    begin $display("FAIL empty_rw_count got %0d exp 1", s_count); n_err++; end
      n_vec++; if (s_empty !== 1'b0)    begin $display("FAIL empty_rw_empty got %b exp 0", s_empty); n_err++; end
      n_vec++; if (s_unf !== 1'b1)      begin $display("FAIL empty_rw_unf got %b exp 1", s_unf); n_err++; end
      n_vec++; if (s_rdata !== 32'd415) begin $display("FAIL empty_rw_rdata got %0d exp 415", s_rdata); n_err++; end
      s_err_clr = 1'b1;
      tick();
      s_err_clr = 1'b0;
      s_pop();
      n_vec++; if (s_rdata !== 32'd555) begin $display("FAIL empty_rw_data got %0d exp 555", s_rdata); n_err++; end
      n_vec++; if (s_empty !== 1'b1)    begin $display("FAIL empty_rw_final got %b exp 1", s_empty); n_err++; end
   endtask

   task automatic test_flush;
      s_pop();
      for (int k = 0; k < 10; k++) s_push(32'(600 + k));
      n_vec++; if (s_count !== 5'd10) begin $display("FAIL flush_pre_count got %0d exp 10", s_count); n_err++; end
      s_flush = 1'b1;
      s_wdata = 32'd777;
      s_wr_en = 1'b1;
      tick();
      s_flush = 1'b0;
      s_wr_en = 1'b0;
      n_vec++; if (s_count !== 5'd0) begin $display("FAIL flush_count got %0d exp 0", s_count); n_err++; end
      n_vec++; if (s_empty !== 1'b1 || s_ae !== 1'b1) begin $display("FAIL flush_empty got empty=%b ae=%b exp 1/1", s_empty, s_ae); n_err++; end
      n_vec++; if (s_unf !== 1'b1 || s_ovf !== 1'b0) begin $display("FAIL flush_err got ovf=%b unf=%b exp 0/1", s_ovf, s_unf); n_err++; end
      s_push(32'd888);
      s_pop();
      n_vec++; if (s_rdata !== 32'd888) begin $display("FAIL flush_next_data got %0d exp 888", s_rdata); n_err++; end
      s_err_clr = 1'b1;
      tick();
      s_err_clr = 1'b0;
   endtask

   task automatic test_reset_mid;
      s_pop();
      for (int k = 0; k < 5; k++) s_push(32'h50 + 32'(k));
      n_vec++; if (s_count !== 5'd5 || s_unf !== 1'b1) begin $display("FAIL rmid_pre got count=%0d unf=%b exp 5/1", s_count, s_unf); n_err++; end
      #2 rst = 1'b0;
      #1;
      n_vec++; if (s_count !== 5'd0) begin $display("FAIL rmid_count got %0d exp 0", s_count); n_err++; end
      n_vec++; if (s_empty !== 1'b1 || s_ae !== 1'b1) begin $display("FAIL rmid_empty got empty=%b ae=%b exp 1/1", s_empty, s_ae); n_err++; end
      n_vec++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin $display("FAIL rmid_err got ovf=%b unf=%b exp 0/0", s_ovf, s_unf); n_err++; end
      n_vec++; if (s_rdata !== 32'd0) begin $display("FAIL rmid_rdata got %h exp 0", s_rdata); n_err++; end
      @(negedge clk);
      rst = 1'b1;
      s_push(32'h42);
      n_vec++; if (s_count !== 5'd1) begin $display("FAIL rmid_post_count got %0d exp 1", s_count); n_err++; end
      s_pop();
      n_vec++; if (s_rdata !== 32'h42 || s_empty !== 1'b1) begin $display("FAIL rmid_post_data got %h empty=%b exp 42/1", s_rdata, s_empty); n_err++; end
   endtask

   task automatic test_fwft;
      n_vec++; if (f_empty !== 1'b1) begin $display("FAIL fwft_pre_empty got %b exp 1", f_empty); n_err++; end
      f_wdata = 32'hA5;
      f_wr_en = 1'b1;
      tick();
      f_wr_en = 1'b0;
      n_vec++; if (f_empty !== 1'b0 || f_rdata !== 32'hA5) begin $display("FAIL fwft_first got empty=%b rdata=%h exp 0/a5", f_empty, f_rdata); n_err++; end
      f_rd_en = 1'b1;
      tick();
      f_rd_en = 1'b0;
      n_vec++; if (f_empty !== 1'b1 || f_count !== 5'd0) begin $display("FAIL fwft_pop got empty=%b count=%0d exp 1/0", f_empty, f_count); n_err++; end
      f_wr_en = 1'b1;
      f_wdata = 32'hB1;
      tick();
      n_vec++; if (f_rdata !== 32'hB1) begin $display("FAIL fwft_b1 got %h exp b1", f_rdata); n_err++; end
      f_wdata = 32'hB2;
      tick();
      f_wr_en = 1'b0;
      n_vec++; if (f_rdata !== 32'hB1 || f_count !== 5'd2) begin $display("FAIL fwft_hold got %h count=%0d exp b1/2", f_rdata, f_count); n_err++; end
      f_rd_en = 1'b1;
      tick();
      n_vec++; if (f_rdata !== 32'hB2 || f_empty !== 1'b0) begin $display("FAIL fwft_b2 got %h empty=%b exp b2/0", f_rdata, f_empty); n_err++; end
      tick();
      f_rd_en = 1'b0;
      n_vec++; if (f_empty !== 1'b1 || f_unf !== 1'b0) begin $display("FAIL fwft_end got empty=%b unf=%b exp 1/0", f_empty, f_unf); n_err++; end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      s_flush = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_err_clr = 1'b0; s_wdata = '0;
      f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0; f_wdata = '0;
      #2 rst = 1'b0;
      #1;
      test_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      test_fill_drain();
      test_overflow_underflow();
      test_simultaneous();
      test_flush();
      test_reset_mid();
      test_fwft();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
